// File: rtl/trace_tag_if.sv
// Handshake and trace bundle between the fetch/control side and the trace_tag tracker.
// The master drives fetch offers and pipeline control; the slave reports per-stage IDs and events.
interface trace_tag_if #(
    parameter int ID_W = 32
) ();
    logic            if_valid;
    logic            if_ready;
    logic            stall;
    logic            flush;
    logic            inst_v_i;
    logic            inst_v_x;
    logic            inst_v_m;
    logic            inst_v_r;
    logic [ID_W-1:0] ci;
    logic [ID_W-1:0] cx;
    logic [ID_W-1:0] cm;
    logic [ID_W-1:0] cr;
    logic            kill_v;
    logic [ID_W-1:0] ck;
    logic [ID_W-1:0] retire_cnt;

    modport master (
        output if_valid, stall, flush,
        input  if_ready, inst_v_i, inst_v_x, inst_v_m, inst_v_r,
        input  ci, cx, cm, cr, kill_v, ck, retire_cnt
    );

    modport slave (
        input  if_valid, stall, flush,
        output if_ready, inst_v_i, inst_v_x, inst_v_m, inst_v_r,
        output ci, cx, cm, cr, kill_v, ck, retire_cnt
    );
endinterface

// File: rtl/trace_tag.sv
// Tags instructions with sequence IDs and follows them through the I/X/M/R stages,
// reporting stage entry pulses, flushed instructions and a retire count.
module trace_tag #(
    parameter int ID_W = 32
) (
    input logic        clk,
    input logic        reset,
    trace_tag_if.slave tif
);
    // Stage index: _p0 = I, _p1 = X, _p2 = M, _p3 = R
    logic            vld_p0, vld_p1, vld_p2, vld_p3;
    logic            fresh_p0, fresh_p1, fresh_p2, fresh_p3;
    logic [ID_W-1:0] id_p0, id_p1, id_p2, id_p3;
    logic [ID_W-1:0] next_id;
    logic [ID_W-1:0] retire_cnt;
    logic            kill_v;
    logic [ID_W-1:0] ck;

    logic accept;
    logic kill;
    logic move_x;
    logic move_m;

    assign accept = tif.if_valid & ~tif.stall;
    assign kill   = tif.flush & vld_p0;
    // A flushed I instruction never advances; X sees a bubble instead.
    assign move_x = ~tif.stall & vld_p0 & ~tif.flush;
    assign move_m = ~tif.stall & vld_p1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            vld_p3     <= 1'b0;
            fresh_p0   <= 1'b0;
            fresh_p1   <= 1'b0;
            fresh_p2   <= 1'b0;
            fresh_p3   <= 1'b0;
            id_p0      <= '0;
            id_p1      <= '0;
            id_p2      <= '0;
            id_p3      <= '0;
            next_id    <= '0;
            retire_cnt <= '0;
            kill_v     <= 1'b0;
            ck         <= '0;
        end else begin
            kill_v <= kill;
            if (kill) begin
                ck <= id_p0;
            end

            // I stage: a stall holds the entry (minus anything flushed), otherwise load the fetch
            if (tif.stall) begin
                vld_p0   <= vld_p0 & ~tif.flush;
                fresh_p0 <= 1'b0;
            end else begin
                vld_p0   <= accept;
                fresh_p0 <= accept;
                if (accept) begin
                    id_p0   <= next_id;
                    next_id <= next_id + ID_W'(1);
                end
            end

            // X stage
            if (tif.stall) begin
                fresh_p1 <= 1'b0;
            end else begin
                vld_p1   <= move_x;
                fresh_p1 <= move_x;
                if (move_x) begin
                    id_p1 <= id_p0;
                end
            end

            // M stage: takes a bubble while I/X are held
            vld_p2   <= move_m;
            fresh_p2 <= move_m;
            if (move_m) begin
                id_p2 <= id_p1;
            end

            // R stage: terminal, never stalls
            vld_p3   <= vld_p2;
            fresh_p3 <= vld_p2;
            if (vld_p2) begin
                id_p3      <= id_p2;
                retire_cnt <= retire_cnt + ID_W'(1);
            end
        end
    end

    assign tif.if_ready   = ~tif.stall;
    assign tif.inst_v_i   = vld_p0 & fresh_p0;
    assign tif.inst_v_x   = vld_p1 & fresh_p1;
    assign tif.inst_v_m   = vld_p2 & fresh_p2;
    assign tif.inst_v_r   = vld_p3 & fresh_p3;
    assign tif.ci         = id_p0;
    assign tif.cx         = id_p1;
    assign tif.cm         = id_p2;
    assign tif.cr         = id_p3;
    assign tif.kill_v     = kill_v;
    assign tif.ck         = ck;
    assign tif.retire_cnt = retire_cnt;
endmodule

// File: tb/tb_trace_tag.sv
// Scoreboard bench for trace_tag: a slot-based pipeline model queues expected stage
// entries, kills and retires; a negedge monitor pops and compares them against the DUT.
module tb_trace_tag;
    localparam int ID_W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    trace_tag_if #(.ID_W(ID_W)) tif ();
    trace_tag #(.ID_W(ID_W)) dut (.clk(clk), .reset(reset), .tif(tif.slave));

    int n_chk = 0;
    int n_err = 0;

    // Reference model: four slots (I, X, M, R), each either empty or holding an ID
    bit              occ [4];
    logic [ID_W-1:0] mid [4];
    logic [ID_W-1:0] nid;
    logic [ID_W-1:0] rcnt;

    logic [ID_W-1:0] q_i[$], q_x[$], q_m[$], q_r[$], q_rc[$], q_k[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus: compute what the edge should produce, then publish it after the edge
    task automatic step(input bit v, input bit s, input bit f, input bit r);
        bit              ev [5];
        logic [ID_W-1:0] eid [5];
        logic [ID_W-1:0] ecnt;
        ecnt = '0;
        for (int i = 0; i < 5; i++) begin
            ev[i]  = 1'b0;
            eid[i] = '0;
        end
        reset        = r;
        tif.if_valid = v;
        tif.stall    = s;
        tif.flush    = f;
        if (!r) begin
            for (int i = 0; i < 4; i++) occ[i] = 1'b0;
            nid  = '0;
            rcnt = '0;
        end else begin
            if (f && occ[0]) begin ev[4] = 1'b1; eid[4] = mid[0]; end
            occ[3] = occ[2];
            if (occ[2]) begin
                mid[3] = mid[2];
                rcnt   = rcnt + 1'b1;
                ev[3]  = 1'b1; eid[3] = mid[2]; ecnt = rcnt;
            end
            occ[2] = !s && occ[1];
            if (occ[2]) begin mid[2] = mid[1]; ev[2] = 1'b1; eid[2] = mid[1]; end
            if (!s) begin
                occ[1] = occ[0] && !f;
                if (occ[1]) begin mid[1] = mid[0]; ev[1] = 1'b1; eid[1] = mid[0]; end
            end
            if (s) begin
                if (f) occ[0] = 1'b0;
            end else begin
                occ[0] = v;
                if (v) begin
                    mid[0] = nid;
                    nid    = nid + 1'b1;
                    ev[0]  = 1'b1; eid[0] = mid[0];
                end
            end
        end
        @(posedge clk);
        #1;
        if (ev[0]) q_i.push_back(eid[0]);
        if (ev[1]) q_x.push_back(eid[1]);
        if (ev[2]) q_m.push_back(eid[2]);
        if (ev[3]) begin q_r.push_back(eid[3]); q_rc.push_back(ecnt); end
        if (ev[4]) q_k.push_back(eid[4]);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".pulses"}, {27'd0, tif.inst_v_i, tif.inst_v_x, tif.inst_v_m, tif.inst_v_r, tif.kill_v}, 32'd0);
        chk({tag, ".ci"}, tif.ci, 0);
        chk({tag, ".cx"}, tif.cx, 0);
        chk({tag, ".cm"}, tif.cm, 0);
        chk({tag, ".cr"}, tif.cr, 0);
        chk({tag, ".ck"}, tif.ck, 0);
        chk({tag, ".retire_cnt"}, tif.retire_cnt, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1);
    endtask

    // Monitor: every pulse must match the head of its queue; leftover entries are missed pulses
    always @(negedge clk) begin
        if (reset === 1'b1 || reset === 1'b0) begin
            chk("if_ready", tif.if_ready, !tif.stall);
            if (tif.inst_v_i) begin
                if (q_i.size() == 0) chk("inst_v_i_unexpected", 1, 0);
                else chk("ci", tif.ci, q_i.pop_front());
            end
            if (tif.inst_v_x) begin
                if (q_x.size() == 0) chk("inst_v_x_unexpected", 1, 0);
                else chk("cx", tif.cx, q_x.pop_front());
            end
            if (tif.inst_v_m) begin
                if (q_m.size() == 0) chk("inst_v_m_unexpected", 1, 0);
                else chk("cm", tif.cm, q_m.pop_front());
            end
            if (tif.inst_v_r) begin
                if (q_r.size() == 0) chk("inst_v_r_unexpected", 1, 0);
                else begin
                    chk("cr", tif.cr, q_r.pop_front());
                    chk("retire_cnt", tif.retire_cnt, q_rc.pop_front());
                end
            end
            if (tif.kill_v) begin
                if (q_k.size() == 0) chk("kill_v_unexpected", 1, 0);
                else chk("ck", tif.ck, q_k.pop_front());
            end
            if (q_i.size() != 0) begin chk("inst_v_i_missing", 0, 1); q_i.delete(); end
            if (q_x.size() != 0) begin chk("inst_v_x_missing", 0, 1); q_x.delete(); end
            if (q_m.size() != 0) begin chk("inst_v_m_missing", 0, 1); q_m.delete(); end
            if (q_r.size() != 0) begin chk("inst_v_r_missing", 0, 1); q_r.delete(); q_rc.delete(); end
            if (q_k.size() != 0) begin chk("kill_v_missing", 0, 1); q_k.delete(); end
        end
    end

    initial begin
        reset        = 1'b0;
        tif.if_valid = 1'b0;
        tif.stall    = 1'b0;
        tif.flush    = 1'b0;
        for (int i = 0; i < 4; i++) begin occ[i] = 1'b0; mid[i] = '0; end
        nid  = '0;
        rcnt = '0;

        // Reset with fetch/flush/stall activity must still clear everything
        step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        check_zero("reset");

        // Four back-to-back accepts, then drain
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
        idle(6);
        chk("retire_after_4", tif.retire_cnt, 4);

        // Stall for two cycles with ID 1 in I and ID 0 in X
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        step(1, 0, 0, 1);
        idle(6);
        chk("retire_after_stall", tif.retire_cnt, rcnt);

        // Flush with concurrent accept while ID 5 sits in I
        step(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
        step(1, 0, 1, 1);
        chk("kill_ck5", tif.ck, 5);
        idle(6);
        chk("retire_after_flush", tif.retire_cnt, 6);

        // Flush and stall together, then the next accept must take ID 6
        step(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
        step(1, 1, 1, 1);
        chk("kill_stall_ck5", tif.ck, 5);
        chk("x_hold_cx4", tif.cx, 4);
        step(1, 0, 0, 1);
        chk("accept_after_kill", tif.ci, 6);
        idle(6);

        // Flush with an empty I stage reports nothing
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        idle(2);

        // Seventeen continuous accepts wrap the 4-bit IDs and the retire count
        step(0, 0, 0, 0);
        for (int i = 0; i < 17; i++) step(1, 0, 0, 1);
        idle(6);
        chk("retire_wrap", tif.retire_cnt, 1);

        // Reset with a full pipeline drops in-flight work silently
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
        step(1, 0, 1, 0);
        check_zero("midreset");
        step(1, 0, 0, 1);
        chk("first_after_reset", tif.ci, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) >= 2);
        end
        idle(6);
        chk("retire_final", tif.retire_cnt, rcnt);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/trace_tag.md
TRACE_TAG -- requirements
Module: trace_tag

Interface
REQ-001 Parameter: ID_W, 32, width of instruction sequence IDs and retire counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising edge of clk).
REQ-004 if_valid  input  1  fetch offers an instruction to I stage this cycle.
REQ-005 if_ready  output  1  I stage can accept; combinational, equals ~stall.
REQ-006 stall  input  1  hold I and X stages this cycle.
REQ-007 flush  input  1  taken branch/jump resolved in X; kills instruction in I.
REQ-008 inst_v_i / inst_v_x / inst_v_m / inst_v_r  output  1 each  one-cycle pulse: instruction newly occupies I / X / M / R.
REQ-009 ci / cx / cm / cr  output  ID_W each  sequence ID held by I / X / M / R stage.
REQ-010 kill_v  output  1  one-cycle pulse: an instruction was flushed.
REQ-011 ck  output  ID_W  ID of flushed instruction, valid when kill_v=1.
REQ-012 retire_cnt  output  ID_W  count of instructions that reached R.

Function
REQ-013 Accept = if_valid & ~stall; each accept assigns next_id to the instruction, then next_id increments by 1.
REQ-014 next_id, IDs and retire_cnt wrap modulo 2^ID_W (all-ones -> 0), no saturation.
REQ-015 Per stage: valid bit, ID register, fresh bit; all outputs driven from registers (except if_ready).
REQ-016 inst_v_<s> = valid_<s> & fresh_<s>; held instruction (stall) keeps valid but fresh cleared, so no repeat pulse.
REQ-017 No stall, no flush: I<-accepted fetch, X<-I, M<-X, R<-M each edge; each moved-in stage gets fresh=1.
REQ-018 Latency: accept at edge k -> inst_v_i at cycle k+1, inst_v_x k+2, inst_v_m k+3, inst_v_r k+4 with no stalls.
REQ-019 Stall: I and X hold (valid, ID kept, fresh cleared); M receives bubble (valid=0); R takes M contents.
REQ-020 Flush (stall=0): if valid_I, I instruction killed -> next cycle kill_v=1, ck=its ID; it never enters X (X gets bubble); same-cycle accept loads I normally (branch target).
REQ-021 Flush & stall same cycle: I killed and reported as in REQ-020; X holds; I becomes empty (if_ready=0 so no accept).
REQ-022 Flush with I empty: no kill_v pulse; otherwise as REQ-020.
REQ-023 R is terminal: instruction leaves R on next edge; inst_v_r pulses exactly once per retired instruction.
REQ-024 retire_cnt increments by 1 on each edge that loads a valid instruction into R; visible with the inst_v_r pulse.
REQ-025 IDs reaching R are strictly increasing (mod 2^ID_W) with gaps only at killed IDs.
REQ-026 ci/cx/cm/cr retain last value when stage invalid; meaningful only with stage valid.

Reset
REQ-027 reset=0 at an edge: all valid/fresh bits, next_id, retire_cnt, kill_v cleared; ci/cx/cm/cr/ck = 0; all pulses 0 the following cycle.
REQ-028 Reset mid-operation discards in-flight instructions with no kill_v or inst_v_r reported; reset dominates flush, stall and if_valid.
REQ-029 First accept after reset release receives ID 0.

Verification
REQ-030 Reset, if_valid=1 for 4 cycles, no stall/flush -> inst_v_i with ci=0,1,2,3 on consecutive cycles; inst_v_r cr=0 exactly 3 cycles after ci=0 pulse; retire_cnt=4 after last.
REQ-031 ID 1 in I, ID 0 in X, stall=1 for 2 cycles -> no inst_v_i/inst_v_x pulses and inst_v_m=0 for those 2 cycles; if_ready=0; then inst_v_x cx=1, inst_v_m cm=0, inst_v_i ci=2.
REQ-032 ID 5 in I, flush=1 with accept -> next cycle kill_v=1, ck=5, inst_v_i ci=6, inst_v_x=0; ID 5 never on cx/cm/cr; retire sequence ...4,6.
REQ-033 ID 5 in I, ID 4 in X, flush=1 & stall=1 -> kill_v=1 ck=5; X still 4 with no inst_v_x pulse; I empty; next accept gets ID 6.
REQ-034 ID_W=4, 17 continuous accepts -> ci sequence 0..15 then 0; retire_cnt wraps 15 -> 0.
REQ-035 Pipeline full (IDs 7..10), reset=0 one cycle -> all outputs 0 next cycle, no kill_v/inst_v_r; first accept afterward gives ci=0.
